// File: rtl/i2s_sample_tx.sv
// Mono 16-bit I2S transmitter with a 4-deep sample FIFO.
// A 2048-clk frame carries the same held sample in both channels.
module i2s_sample_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        mclk,
  output logic        lrck,
  output logic        sclk,
  output logic        sdin,
  output logic        frame_tick,
  output logic [2:0]  fifo_level,
  output logic        underrun,
  input  logic        underrun_clr
);

  logic [10:0] cnt;
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  level;
  logic [2:0]  level_next;
  logic [15:0] hold;
  logic        sdin_q;
  logic        underrun_q;
  logic        frame_end;
  logic        push;
  logic        pop;
  logic [4:0]  next_slot;
  logic [4:0]  bit_idx;
  logic        slot_bit;

  // Handshake: a sample transfers on a rising edge where sample_valid and
  // sample_ready are both 1; valid without ready is ignored with no state change.
  assign sample_ready = (level != 3'd4);
  assign frame_end    = (cnt == 11'd2047);
  assign push         = sample_valid && sample_ready;
  assign pop          = frame_end && (level != 3'd0);

  assign mclk       = cnt[2];
  assign sclk       = cnt[4];
  assign lrck       = cnt[10];
  assign sdin       = sdin_q;
  assign frame_tick = frame_end;
  assign fifo_level = level;
  assign underrun   = underrun_q;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 3'd1;
      2'b01:   level_next = level - 3'd1;
      default: level_next = level;
    endcase
  end

  // Bit shifted out during the next slot; MSB lands in slot 1 (one-bit I2S delay).
  always_comb begin
    next_slot = cnt[9:5] + 5'd1;
    bit_idx   = 5'd16 - next_slot;
    slot_bit  = 1'b0;
    if (next_slot >= 5'd1 && next_slot <= 5'd16)
      slot_bit = hold[bit_idx[3:0]];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 11'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      level      <= 3'd0;
      hold       <= 16'd0;
      sdin_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt   <= cnt + 11'd1;
      level <= level_next;
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (cnt[4:0] == 5'd31)
        sdin_q <= slot_bit;
      // A new empty-frame event takes priority over a clear in the same cycle.
      if (frame_end && level == 3'd0)
        underrun_q <= 1'b1;
      else if (underrun_clr)
        underrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: clock waveforms, serial framing,
// FIFO flow control, underrun behaviour and mid-frame reset.
module tb_i2s_sample_tx;

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        mclk;
  logic        lrck;
  logic        sclk;
  logic        sdin;
  logic        frame_tick;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        underrun_clr;

  logic [10:0] tc;
  int          checks;
  int          errors;

  i2s_sample_tx dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mclk         (mclk),
    .lrck         (lrck),
    .sclk         (sclk),
    .sdin         (sdin),
    .frame_tick   (frame_tick),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tc mirrors the DUT frame counter as seen at each falling edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      tc = tc + 11'd1;
    end
  endtask

  task automatic go_to(input int t);
    adv((t - int'(tc) + 2048) % 2048);
  endtask

  // From tc=0 to tc=2047, sample sdin mid-slot into one 32-bit word per channel.
  task automatic capture(output logic [31:0] l, output logic [31:0] r);
    l = 32'd0;
    r = 32'd0;
    repeat (2047) begin
      if (tc[4:0] == 5'd16) begin
        if (!tc[10]) l = {l[30:0], sdin};
        else         r = {r[30:0], sdin};
      end
      adv(1);
    end
  endtask

  function automatic logic [31:0] word(input logic [15:0] v);
    return {1'b0, v, 15'd0};
  endfunction

  task automatic push_one(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    adv(1);
    sample_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    underrun_clr = 1'b1;
    adv(1);
    underrun_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] wl;
    logic [31:0] wr;
    int bad_clk;
    int bad_tick;
    int ticks;
    int sd_ones;
    int mclk_hi;
    int sclk_hi;
    int lrck_hi;

    checks = 0;
    errors = 0;
    tc = 11'd0;
    rst = 1'b1;
    sample_in = 16'h1234;
    sample_valid = 1'b1;
    underrun_clr = 1'b0;

    // Reset state, with push attempts ignored
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, mclk, lrck, sclk, sdin, frame_tick, underrun}, 32'd0);
    chk("reset_level", {29'd0, fifo_level}, 32'd0);
    chk("reset_ready", {31'd0, sample_ready}, 32'd1);
    sample_valid = 1'b0;
    rst = 1'b0;
    tc = 11'd0;

    // Two frames of clock waveforms
    bad_clk = 0; bad_tick = 0; ticks = 0; sd_ones = 0;
    mclk_hi = 0; sclk_hi = 0; lrck_hi = 0;
    for (int i = 0; i < 4096; i++) begin
      if (mclk !== tc[2] || sclk !== tc[4] || lrck !== tc[10]) bad_clk++;
      if (frame_tick !== (tc == 11'd2047)) bad_tick++;
      if (frame_tick === 1'b1) ticks++;
      if (sdin === 1'b1) sd_ones++;
      if (mclk === 1'b1) mclk_hi++;
      if (sclk === 1'b1) sclk_hi++;
      if (lrck === 1'b1) lrck_hi++;
      adv(1);
    end
    chk("clk_wave_errs", bad_clk, 0);
    chk("tick_pos_errs", bad_tick, 0);
    chk("tick_count", ticks, 2);
    chk("mclk_duty", mclk_hi, 2048);
    chk("sclk_duty", sclk_hi, 2048);
    chk("lrck_duty", lrck_hi, 2048);
    chk("idle_sdin_zero", sd_ones, 0);
    chk("idle_underrun", {31'd0, underrun}, 32'd1);
    clr_pulse();
    chk("underrun_cleared", {31'd0, underrun}, 32'd0);

    // Single sample 0xA5C3 through both channels
    go_to(100);
    chk("a5_ready", {31'd0, sample_ready}, 32'd1);
    push_one(16'hA5C3);
    chk("a5_level1", {29'd0, fifo_level}, 32'd1);
    go_to(2047);
    chk("a5_tick", {31'd0, frame_tick}, 32'd1);
    adv(1);
    chk("a5_popped", {29'd0, fifo_level}, 32'd0);
    chk("a5_no_underrun", {31'd0, underrun}, 32'd0);
    capture(wl, wr);
    chk("a5_left", wl, word(16'hA5C3));
    chk("a5_right", wr, word(16'hA5C3));
    adv(1);
    chk("a5_underrun_after", {31'd0, underrun}, 32'd1);

    // 0x7FFF once, then repeat on underrun
    go_to(10);
    push_one(16'h7FFF);
    go_to(20);
    clr_pulse();
    chk("7f_clr", {31'd0, underrun}, 32'd0);
    go_to(2047);
    adv(1);
    chk("7f_no_underrun", {31'd0, underrun}, 32'd0);
    capture(wl, wr);
    chk("7f_frame1_left", wl, word(16'h7FFF));
    chk("7f_frame1_right", wr, word(16'h7FFF));
    adv(1);
    chk("7f_underrun_set", {31'd0, underrun}, 32'd1);
    capture(wl, wr);
    chk("7f_frame2_left", wl, word(16'h7FFF));
    chk("7f_frame2_right", wr, word(16'h7FFF));
    underrun_clr = 1'b1;
    adv(1);
    underrun_clr = 1'b0;
    chk("set_wins_over_clr", {31'd0, underrun}, 32'd1);
    go_to(5);
    clr_pulse();
    chk("clr_again", {31'd0, underrun}, 32'd0);
    go_to(2047);
    chk("clr_holds", {31'd0, underrun}, 32'd0);
    adv(1);
    chk("reset_on_empty", {31'd0, underrun}, 32'd1);

    // Fill to four entries, boundary pushes at frame end
    clr_pulse();
    go_to(100);
    for (int k = 1; k <= 4; k++) begin
      chk("fill_ready", {31'd0, sample_ready}, 32'd1);
      sample_in = 16'(k);
      sample_valid = 1'b1;
      adv(1);
    end
    sample_in = 16'd5;
    chk("full_not_ready", {31'd0, sample_ready}, 32'd0);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    adv(1);
    chk("full_ignored", {29'd0, fifo_level}, 32'd4);
    sample_valid = 1'b0;
    go_to(2047);
    sample_in = 16'd99;
    sample_valid = 1'b1;
    chk("full_tick_not_ready", {31'd0, sample_ready}, 32'd0);
    adv(1);
    sample_valid = 1'b0;
    chk("full_pop_level", {29'd0, fifo_level}, 32'd3);
    capture(wl, wr);
    chk("order_1_left", wl, word(16'd1));
    chk("order_1_right", wr, word(16'd1));
    chk("three_level", {29'd0, fifo_level}, 32'd3);
    sample_in = 16'd5;
    sample_valid = 1'b1;
    chk("three_ready", {31'd0, sample_ready}, 32'd1);
    adv(1);
    sample_valid = 1'b0;
    chk("push_pop_level", {29'd0, fifo_level}, 32'd3);
    for (int k = 2; k <= 5; k++) begin
      capture(wl, wr);
      chk("order_left", wl, word(16'(k)));
      chk("order_right", wr, word(16'(k)));
      chk("order_no_underrun", {31'd0, underrun}, 32'd0);
      adv(1);
    end
    chk("drained_level", {29'd0, fifo_level}, 32'd0);
    chk("drained_underrun", {31'd0, underrun}, 32'd1);

    // Mid-frame reset with two samples queued
    clr_pulse();
    go_to(50);
    push_one(16'h1111);
    push_one(16'h2222);
    go_to(1200);
    chk("pre_reset_level", {29'd0, fifo_level}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {26'd0, mclk, lrck, sclk, sdin, frame_tick, underrun}, 32'd0);
    chk("midrst_level", {29'd0, fifo_level}, 32'd0);
    chk("midrst_ready", {31'd0, sample_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tc = 11'd0;
    capture(wl, wr);
    chk("post_rst_left", wl, 32'd0);
    chk("post_rst_right", wr, 32'd0);
    chk("post_rst_tick", {31'd0, frame_tick}, 32'd1);
    chk("post_rst_no_underrun", {31'd0, underrun}, 32'd0);
    adv(1);
    chk("post_rst_underrun", {31'd0, underrun}, 32'd1);
    chk("post_rst_level", {29'd0, fifo_level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
